// File: rtl/ser_pkg.sv
// Shared definitions for the serial word deframer: FSM state encoding and
// the meaning of the dir input.
package ser_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/ser_bit_counter.sv
// Data-bit counter for the deframer; tc flags the position of the last
// data bit of a frame.
module ser_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/ser_word_deframer.sv
// Serial word deframer: start-bit detect, WIDTH-bit collection in either
// bit order, and a one-entry valid/ready output buffer with sticky overrun.
//
//   state   | meaning
//   IDLE    | waiting for a start bit (1) on a bit_en edge
//   DATA    | shifting in data bits; leaves after the last bit is sampled
module ser_word_deframer
  import ser_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ser_in,
  input  logic             bit_en,
  input  logic             dir,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lsbf,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

  state_t           state_q, state_d;
  logic             start;
  logic             word_done;
  logic             tc;
  logic             dir_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_next;
  logic             buf_free;

  ser_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (start),
    .en      (state_q == ST_DATA && bit_en),
    .tc      (tc)
  );

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    word_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bit_en && ser_in) begin
          start   = 1'b1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_en && tc) begin
          word_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The completed word includes the bit sampled on this very edge.
  always_comb begin
    sh_next = sh_q;
    if (dir_q == LSB_FIRST) begin
      sh_next = {ser_in, sh_q[WIDTH-1:1]};
    end else begin
      sh_next = {sh_q[WIDTH-2:0], ser_in};
    end
  end

  assign buf_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        dir_q <= dir;
        sh_q  <= '0;
      end else if (state_q == ST_DATA && bit_en) begin
        sh_q <= sh_next;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_lsbf  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (word_done && buf_free) begin
        out_data  <= sh_next;
        out_lsbf  <= dir_q;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A drop in the same cycle as clr_ovr leaves overrun set.
      if (word_done && !buf_free) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (state_q == ST_DATA);

endmodule

// File: tb/tb_ser_word_deframer.sv
// Self-checking bench for ser_word_deframer: delivered words are queued by the
// driver and compared on each output handshake; flags are checked directly.
module tb_ser_word_deframer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             reset_n;
  logic             ser_in;
  logic             bit_en;
  logic             dir;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_lsbf;
  logic             busy;
  logic             overrun;
  logic             clr_ovr;

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH:0] sb_q[$];

  ser_word_deframer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ser_in    (ser_in),
    .bit_en    (bit_en),
    .dir       (dir),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lsbf  (out_lsbf),
    .busy      (busy),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_in = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    ser_in = 1'b0;
  endtask

  // Start bit then WIDTH data bits back to back; optionally raises out_ready
  // only for the last data bit so completion and acceptance share an edge.
  task automatic send_frame(input logic d, input logic [WIDTH-1:0] w,
                            input bit deliver, input bit ready_last);
    dir = d;
    send_bit(1'b1);
    dir = ~d;
    for (int i = 0; i < WIDTH; i++) begin
      if (ready_last && i == WIDTH - 1) out_ready = 1'b1;
      send_bit(d ? w[i] : w[WIDTH-1-i]);
    end
    if (ready_last) out_ready = 1'b0;
    if (deliver) sb_q.push_back({d, w});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", sb_q.size(), 1);
      end else begin
        chk("word", {out_lsbf, out_data}, sb_q.pop_front());
      end
    end
  end

  initial begin
    logic [1:0] pat;
    reset_n   = 1'b0;
    ser_in    = 1'b0;
    bit_en    = 1'b0;
    dir       = 1'b0;
    out_ready = 1'b1;
    clr_ovr   = 1'b0;
    idle(2);
    chk("reset_outs", {out_data, out_valid, out_lsbf, busy, overrun}, 0);
    reset_n = 1'b1;
    idle(2);

    // 1: LSB-first 1,0,1,1 -> 4'b1101, valid one clock after last bit
    dir = 1'b1;
    send_bit(1'b1);
    chk("s1_busy", busy, 1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("s1_pre_valid", out_valid, 0);
    send_bit(1'b1);
    sb_q.push_back({1'b1, 4'b1101});
    chk("s1_valid", out_valid, 1);
    chk("s1_busy_done", busy, 0);
    idle(3);
    chk("s1_drained", out_valid, 0);

    // 2: same stream MSB-first -> 4'b1011
    dir = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    sb_q.push_back({1'b0, 4'b1011});
    chk("s2_valid", out_valid, 1);
    idle(3);

    // 3: consumer stalled, second word dropped
    out_ready = 1'b0;
    send_frame(1'b1, 4'hA, 1'b1, 1'b0);
    send_frame(1'b1, 4'h5, 1'b0, 1'b0);
    idle(2);
    chk("s3_hold_data", out_data, 4'hA);
    chk("s3_valid", out_valid, 1);
    chk("s3_overrun", overrun, 1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    chk("s3_clr_ovr", overrun, 0);
    out_ready = 1'b1;
    tick();
    chk("s3_drained", out_valid, 0);

    // 4: completion on the acceptance edge
    out_ready = 1'b0;
    send_frame(1'b1, 4'hC, 1'b1, 1'b0);
    send_frame(1'b0, 4'h3, 1'b1, 1'b1);
    chk("s4_valid", out_valid, 1);
    chk("s4_no_ovr", overrun, 0);
    chk("s4_data", out_data, 4'h3);
    out_ready = 1'b1;
    idle(2);
    chk("s4_drained", out_valid, 0);

    // 5: bit_en gapped, garbage on ser_in while disabled
    dir = 1'b1;
    pat = 2'b11;
    send_bit(1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      for (int g = 0; g < 2; g++) begin
        ser_in = g[0] ^ pat[0];
        tick();
        chk("s5_busy", busy, 1);
      end
      pat = ~pat;
      send_bit(i == 1 ? 1'b0 : 1'b1);
    end
    sb_q.push_back({1'b1, 4'b1101});
    chk("s5_busy_done", busy, 0);
    idle(3);

    // 6: reset mid-frame wipes buffer and partial word
    out_ready = 1'b0;
    send_frame(1'b1, 4'h9, 1'b0, 1'b0);
    dir = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    reset_n = 1'b0;
    #2;
    chk("s6_reset_outs", {out_data, out_valid, out_lsbf, busy, overrun}, 0);
    tick();
    reset_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send_frame(1'b0, 4'h6, 1'b1, 1'b0);
    chk("s6_data", out_data, 4'h6);
    idle(3);

    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
